// File: rtl/m_fetch_ctrl_if.sv
// Bus bundle for m_fetch_ctrl: redirect input, instruction-memory req/ack port and decode port.
// Defining FETCH_PERF_CNT_EN adds the two performance counter outputs.
interface m_fetch_ctrl_if;
  // Memory: w_mem_req/w_mem_addr hold until a posedge samples w_mem_ack=1 (ack may come in the first cycle).
  // Decode: an entry transfers on a posedge where w_ir_valid & w_ir_ready; head is stable while valid & !ready.
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic        w_mem_ack;
  logic [31:0] w_mem_rdata;
  logic        w_ir_valid;
  logic [31:0] w_ir;
  logic [31:0] w_ir_pc;
  logic        w_ir_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] w_perf_fetched;
  logic [31:0] w_perf_killed;

  modport master (
    input  w_redirect, w_redirect_pc, w_mem_ack, w_mem_rdata, w_ir_ready,
    output w_mem_req, w_mem_addr, w_ir_valid, w_ir, w_ir_pc, w_perf_fetched, w_perf_killed
  );
  modport slave (
    output w_redirect, w_redirect_pc, w_mem_ack, w_mem_rdata, w_ir_ready,
    input  w_mem_req, w_mem_addr, w_ir_valid, w_ir, w_ir_pc, w_perf_fetched, w_perf_killed
  );
`else
  modport master (
    input  w_redirect, w_redirect_pc, w_mem_ack, w_mem_rdata, w_ir_ready,
    output w_mem_req, w_mem_addr, w_ir_valid, w_ir, w_ir_pc
  );
  modport slave (
    output w_redirect, w_redirect_pc, w_mem_ack, w_mem_rdata, w_ir_ready,
    input  w_mem_req, w_mem_addr, w_ir_valid, w_ir, w_ir_pc
  );
`endif
endinterface

// File: rtl/m_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding memory request, small instruction queue, redirect flush.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module m_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          Q_DEPTH  = 2
) (
  input  logic           w_clock,
  input  logic           w_reset,
  m_fetch_ctrl_if.master bus,
  output logic [1:0]     o_dbg_state
);
  localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW = $clog2(Q_DEPTH) + 1;
  localparam logic [CW-1:0] LP_QMAX = CW'(Q_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc, w_pc_nxt;
  logic [31:0]   r_req_addr, w_req_addr_nxt;
  logic [31:0]   r_q_ir [Q_DEPTH];
  logic [31:0]   r_q_pc [Q_DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [31:0]   w_redir_pc;
  logic          w_ack_busy, w_push, w_pop, w_credit;

  assign w_redir_pc  = bus.w_redirect_pc & 32'hFFFF_FFFC;
  assign w_ack_busy  = (r_state == S_BUSY) && bus.w_mem_ack;
  assign w_push      = w_ack_busy && !bus.w_redirect;
  assign w_pop       = (r_count != '0) && bus.w_ir_ready && !bus.w_redirect;
  assign w_count_nxt = bus.w_redirect ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  // Credit looks at the post-push/pop count so a new request always has a free slot waiting.
  assign w_credit    = (w_count_nxt <= LP_QMAX);

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_addr_nxt = r_req_addr;
    if (bus.w_redirect) begin
      w_pc_nxt = w_redir_pc;
      case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_BUSY;
          w_req_addr_nxt = w_redir_pc;
        end
        S_BUSY: begin
          if (bus.w_mem_ack) w_req_addr_nxt = w_redir_pc;
          else               w_state_nxt    = S_KILL;
        end
        default: w_state_nxt = S_KILL;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_credit) begin
            w_state_nxt    = S_BUSY;
            w_req_addr_nxt = r_pc;
          end
        end
        S_BUSY: begin
          if (bus.w_mem_ack) begin
            w_pc_nxt = r_pc + 32'd4;
            if (w_credit) w_req_addr_nxt = r_pc + 32'd4;
            else          w_state_nxt    = S_IDLE;
          end
        end
        S_KILL: begin
          // Stale response dropped; the flush left the queue empty so credit is guaranteed.
          if (bus.w_mem_ack) begin
            w_state_nxt    = S_BUSY;
            w_req_addr_nxt = r_pc;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        r_q_ir[i] <= '0;
        r_q_pc[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (bus.w_redirect) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_q_ir[r_tail] <= bus.w_mem_rdata;
          r_q_pc[r_tail] <= r_req_addr;
          r_tail         <= r_tail + PW'(1);
        end
        if (w_pop) r_head <= r_head + PW'(1);
      end
    end
  end

  assign bus.w_mem_req  = (r_state == S_BUSY) || (r_state == S_KILL);
  assign bus.w_mem_addr = r_req_addr;
  assign bus.w_ir_valid = (r_count != '0);
  assign bus.w_ir       = r_q_ir[r_head];
  assign bus.w_ir_pc    = r_q_pc[r_head];
  assign o_dbg_state    = r_state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_killed;
  logic        w_kill_ack;

  assign w_kill_ack = ((r_state == S_KILL) && bus.w_mem_ack) || (w_ack_busy && bus.w_redirect);

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_perf_fetched <= '0;
      r_perf_killed  <= '0;
    end else begin
      if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
      r_perf_killed <= r_perf_killed + 32'(w_kill_ack) + (bus.w_redirect ? 32'(r_count) : 32'd0);
    end
  end

  assign bus.w_perf_fetched = r_perf_fetched;
  assign bus.w_perf_killed  = r_perf_killed;
`endif
endmodule

// File: tb/tb_m_fetch_ctrl.sv
// Self-checking bench for m_fetch_ctrl: transaction-level model of fetch requests and the instruction
// queue, directed scenarios with literal expectations, then randomized redirects/backpressure/latency.
module tb_m_fetch_ctrl;
  localparam int          QD     = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic       w_clock = 1'b0;
  logic       w_reset;
  logic [1:0] dbg_state;

  m_fetch_ctrl_if bus ();

  m_fetch_ctrl #(.RESET_PC(RST_PC), .Q_DEPTH(QD)) dut (
    .w_clock    (w_clock),
    .w_reset    (w_reset),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  always #5 w_clock = ~w_clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];     // {pc, instruction} entries the decode side must see, head first
  logic [31:0] m_pc;         // next address to fetch
  logic [31:0] m_addr;       // address of the outstanding request
  logic        m_active;     // a request is outstanding
  logic        m_stale;      // outstanding request was overtaken by a redirect
  logic [31:0] m_fetched, m_killed;
  bit          chk_en   = 1'b0;
  bit          mem_rand = 1'b0;
  int          mem_lat  = 1;
  int          wait_cnt = 0;
  int          got_n;
  logic [31:0] got [2];
  bit          found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc      = RST_PC;
    m_addr    = '0;
    m_active  = 1'b0;
    m_stale   = 1'b0;
    m_fetched = '0;
    m_killed  = '0;
    wait_cnt  = 0;
  endtask

  // One clock edge of the fetch unit in request/queue terms.
  task automatic model_step(input logic redir, input logic [31:0] rpc, input logic ack, input logic rdy);
    logic [31:0] tgt;
    tgt = rpc & 32'hFFFF_FFFC;
    if (redir) begin
      m_killed += 32'(exp_q.size());
      exp_q.delete();
      if (m_active && ack) m_killed += 32'd1;
      if (!m_active) begin
        m_active = 1'b1;
        m_stale  = 1'b0;
        m_addr   = tgt;
      end else if (!m_stale) begin
        if (ack) m_addr = tgt;
        else     m_stale = 1'b1;
      end
      m_pc = tgt;
    end else begin
      if (exp_q.size() > 0 && rdy) begin
        void'(exp_q.pop_front());
        m_fetched += 32'd1;
      end
      if (m_active && ack) begin
        if (m_stale) begin
          m_killed += 32'd1;
          m_stale   = 1'b0;
          m_addr    = m_pc;
        end else begin
          exp_q.push_back({m_addr, imem(m_addr)});
          m_pc = m_pc + 32'd4;
          if (exp_q.size() <= QD - 1) m_addr   = m_pc;
          else                        m_active = 1'b0;
        end
      end else if (!m_active && exp_q.size() <= QD - 1) begin
        m_active = 1'b1;
        m_addr   = m_pc;
      end
    end
  endtask

  // Called just after a negedge: drive one cycle of inputs, advance the model, wait for the next negedge.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
    logic ack;
    logic was_active;
    was_active = m_active;
    if (mem_rand) ack = m_active && ($urandom_range(0, 2) == 0);
    else          ack = m_active && (wait_cnt + 1 >= mem_lat);
    bus.w_redirect    = redir;
    bus.w_redirect_pc = rpc;
    bus.w_ir_ready    = rdy;
    bus.w_mem_ack     = ack;
    bus.w_mem_rdata   = ack ? imem(m_addr) : $urandom;
    model_step(redir, rpc, ack, rdy);
    if (ack || !was_active) wait_cnt = 0;
    else                    wait_cnt++;
    @(posedge w_clock);
    @(negedge w_clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(bus.w_mem_req), 32'd0);
    check({tag, "_valid"}, 32'(bus.w_ir_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_perf_fetched"}, bus.w_perf_fetched, 32'd0);
    check({tag, "_perf_killed"},  bus.w_perf_killed,  32'd0);
`endif
  endtask

  task automatic do_reset();
    chk_en            = 1'b0;
    w_reset           = 1'b1;
    bus.w_redirect    = 1'b0;
    bus.w_redirect_pc = '0;
    bus.w_mem_ack     = 1'b0;
    bus.w_mem_rdata   = '0;
    bus.w_ir_ready    = 1'b0;
    model_reset();
    repeat (2) @(negedge w_clock);
    #1;
    check_reset_outputs("rst");
    check("rst_addr",  bus.w_mem_addr, 32'd0);
    check("rst_ir",    bus.w_ir,       32'd0);
    check("rst_ir_pc", bus.w_ir_pc,    32'd0);
    w_reset = 1'b0;
    chk_en  = 1'b1;
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge w_clock) begin
    if (chk_en && !w_reset) begin
      check("mem_req", 32'(bus.w_mem_req), 32'(m_active));
      if (m_active) check("mem_addr", bus.w_mem_addr, m_addr);
      check("ir_valid", 32'(bus.w_ir_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("ir_pc", bus.w_ir_pc, exp_q[0][63:32]);
        check("ir",    bus.w_ir,    exp_q[0][31:0]);
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", bus.w_perf_fetched, m_fetched);
      check("perf_killed",  bus.w_perf_killed,  m_killed);
`endif
    end
  end

  initial begin
    w_reset = 1'b1;
    do_reset();

    // Zero-wait memory, decode always ready: one instruction per cycle from cycle 2.
    mem_lat = 1;
    step(1'b0, '0, 1'b1);
    check("s1_c1_valid", 32'(bus.w_ir_valid), 32'd0);
    check("s1_c1_req",   32'(bus.w_mem_req),  32'd1);
    check("s1_c1_addr",  bus.w_mem_addr,      32'h0);
    step(1'b0, '0, 1'b1);
    check("s1_c2_ir_pc", bus.w_ir_pc, 32'h0);
    check("s1_c2_ir",    bus.w_ir,    imem(32'h0));
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, '0, 1'b1);
      check("s1_seq_ir_pc", bus.w_ir_pc, 32'(4 * k));
    end

    // Asynchronous reset between clock edges while a request is live.
    chk_en = 1'b0;
    #2;
    w_reset = 1'b1;
    #1;
    check_reset_outputs("s6_async");
    do_reset();

    // Backpressure: queue fills, request drops, head holds, then drains without loss.
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    repeat (5) step(1'b0, '0, 1'b0);
    check("s2_hold_req",   32'(bus.w_mem_req),  32'd0);
    check("s2_hold_valid", 32'(bus.w_ir_valid), 32'd1);
    check("s2_hold_ir_pc", bus.w_ir_pc,         32'h0);
    step(1'b0, '0, 1'b1);
    check("s2_resume_pc4", bus.w_ir_pc, 32'h4);
    step(1'b0, '0, 1'b1);
    check("s2_resume_pc8", bus.w_ir_pc, 32'h8);

    // Three-cycle memory latency.
    mem_lat = 3;
    repeat (18) step(1'b0, '0, 1'b1);

    // Redirect while the request for 0x8 is still waiting.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_active && !m_stale && m_addr == 32'h8 && (wait_cnt + 1 < mem_lat)) begin
        found = 1'b1;
        break;
      end
      step(1'b0, '0, 1'b1);
    end
    check("s4_reached_0x8", 32'(found), 32'd1);
    step(1'b1, 32'h100, 1'b1);
    check("s4_valid_after_redir", 32'(bus.w_ir_valid), 32'd0);
    check("s4_req_kept",          32'(bus.w_mem_req),  32'd1);
    got_n  = 0;
    got[0] = '0;
    got[1] = '0;
    for (int i = 0; i < 60 && got_n < 2; i++) begin
      if (bus.w_ir_valid) begin
        got[got_n] = bus.w_ir_pc;
        got_n++;
      end
      step(1'b0, '0, 1'b1);
    end
    check("s4_delivered", 32'(got_n), 32'd2);
    check("s4_first_pc",  got[0],     32'h100);
    check("s4_second_pc", got[1],     32'h104);

    // Redirect coincident with ack and pop, zero-wait memory.
    mem_lat = 1;
    repeat (4) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h200, 1'b1);
    check("s5_valid_flushed", 32'(bus.w_ir_valid), 32'd0);
    check("s5_addr",          bus.w_mem_addr,      32'h200);
    step(1'b0, '0, 1'b1);
    check("s5_first_pc", bus.w_ir_pc, 32'h200);
    step(1'b0, '0, 1'b1);
    check("s5_next_pc",  bus.w_ir_pc, 32'h204);

    // Unaligned redirect near the top of the address space: low bits dropped, PC wraps to 0.
    step(1'b1, 32'hFFFF_FFFB, 1'b1);
    check("wrap_addr", bus.w_mem_addr, 32'hFFFF_FFF8);
    step(1'b0, '0, 1'b1);
    check("wrap_pc_f8", bus.w_ir_pc, 32'hFFFF_FFF8);
    step(1'b0, '0, 1'b1);
    check("wrap_pc_fc", bus.w_ir_pc, 32'hFFFF_FFFC);
    step(1'b0, '0, 1'b1);
    check("wrap_pc_0",  bus.w_ir_pc, 32'h0);

    // Random latency, backpressure and redirects.
    mem_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic        r_redir;
      logic [31:0] r_tgt;
      r_redir = ($urandom_range(0, 24) == 0);
      r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      step(r_redir, r_tgt, $urandom_range(0, 3) != 0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/m_fetch_ctrl.md
Name: m_fetch_ctrl

Overview:
- Instruction-fetch sequencer between the PC datapath and an instruction memory with a req/ack handshake.
- Generates fetch addresses (PC, PC+4, ...) and issues one memory request at a time.
- Buffers returned instructions in a small queue and presents them to decode with a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0, PC loaded on reset; bits [1:0] must be 0.
Q_DEPTH, 2, instruction queue entries; power of 2, minimum 2.

Ports:
w_clock  in  1  clock, rising edge.
w_reset  in  1  asynchronous reset, active-high.
w_redirect  in  1  one-cycle pulse: restart fetch at w_redirect_pc.
w_redirect_pc  in  32  redirect target; bits [1:0] ignored, forced to 0.
w_mem_req  out  1  memory request.
w_mem_addr  out  32  request address; registered, stable while w_mem_req=1.
w_mem_ack  in  1  response strobe, sampled at posedge; may be high in the first req cycle (zero-wait memory).
w_mem_rdata  in  32  instruction data, valid when w_mem_ack=1.
w_ir_valid  out  1  queue head valid.
w_ir  out  32  queue head instruction.
w_ir_pc  out  32  queue head PC.
w_ir_ready  in  1  decode accepts head; pop when valid&ready.

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - state=S_IDLE, r_pc=RESET_PC, queue count=0.
  - w_mem_req=0, w_ir_valid=0, w_mem_addr=0, w_ir=0, w_ir_pc=0.
  - Reset mid-request abandons the request; memory tolerates req dropping without ack.
- Credit rule: a new request starts only if count_next <= Q_DEPTH-1, where count_next is the count after this cycle's push/pop. This guarantees an ack always finds space.
- At most one request outstanding.
- w_mem_req=1 exactly in S_BUSY and S_KILL.
- States:
  - S_IDLE: no request. If credit is available → S_BUSY, r_req_addr<=r_pc.
  - S_BUSY: req held with r_req_addr.
    - On ack: push {rdata, r_req_addr}, r_pc<=r_pc+4.
    - Then if credit: stay S_BUSY with r_req_addr<=r_pc+4; else → S_IDLE.
    - No ack: hold req and address unchanged.
  - S_KILL: req held with the stale address.
    - On ack: discard data, r_req_addr<=r_pc → S_BUSY (queue is empty, so credit exists).
- Redirect (priority over all other events in the cycle):
  - Queue flushed (count<=0; w_ir_valid=0 next cycle); a same-cycle pop is ignored.
  - r_pc<=redirect_pc.
  - In S_IDLE → S_BUSY with r_req_addr<=redirect_pc.
  - In S_BUSY with ack same cycle → data discarded, S_BUSY with r_req_addr<=redirect_pc.
  - In S_BUSY without ack → S_KILL.
  - In S_KILL → stay S_KILL, r_pc updated (latest redirect wins).
- Push and pop in the same cycle: count unchanged. Head/tail pointers wrap modulo Q_DEPTH.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
- Throughput: with zero-wait memory and ready=1, one instruction per cycle.
- Latency: first w_ir_valid 2 cycles after reset release (edge 1 enters S_BUSY, edge 2 pushes).
- Head outputs stable while valid & !ready.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs w_perf_fetched [31:0] and w_perf_killed [31:0], both reset to 0.
  - w_perf_fetched increments on each pop.
  - w_perf_killed increments per discarded ack plus per valid entry flushed by redirect.
  - Both wrap on overflow.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, ack tied 1, ready=1 → w_ir_pc sequence 0,4,8,C one per cycle from cycle 2; w_ir equals imem word at each address.
- ready=0 from cycle 3 → two entries queued, req drops, head holds (pc 0x0). Ready=1 after 5 cycles → sequence resumes with no loss or duplication.
- ack delayed 3 cycles per request → w_mem_addr stable through each wait; one instruction per 3 cycles; PCs consecutive.
- Redirect to 0x100 while req at 0x8 is unacked → S_KILL; 0x8 data discarded; w_ir_valid=0 next cycle; next delivered w_ir_pc=0x100 then 0x104.
- Redirect to 0x200 coincident with ack and pop → acked data discarded, pop ignored; next delivered w_ir_pc=0x200.
- w_reset asserted mid-request between clock edges → w_mem_req and w_ir_valid fall immediately. After release, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, both counters read 0.
